fetch_unit: RTL and testbench

- Front end of the VLIW pipeline, directly upstream of the instruction cache.
- Owns the fetch PC and issues one bundle-aligned request at a time to the instruction cache.
- Handles cache miss stalls and refill retry, plus branch/exception redirects.
- Buffers returned bundles in a small FIFO that feeds decode/issue with a valid/ready handshake.

---
 rtl/fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_fetch_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// VLIW fetch front end: owns the fetch PC, keeps one bundle request in flight to the
// I-cache, and queues returned bundles for decode. Optional counters: FETCH_STATS_EN.
module fetch_unit #(
   parameter int NFU                                     = 2,
   parameter int PHYSICAL_ADDRESS_LENGTH                 = 56,
   parameter int QUEUE_DEPTH                             = 4,
   parameter logic [PHYSICAL_ADDRESS_LENGTH-1:0] RESET_PC = '0
) (
   input  logic                               clk,
   input  logic                               rst_n,
   output logic                               cache_req,
   output logic [PHYSICAL_ADDRESS_LENGTH-1:0] cache_addr,
   input  logic                               cache_resp_valid,
   input  logic                               cache_miss,
   input  logic [NFU*32-1:0]                  cache_data,
   input  logic                               refill_done,
   input  logic                               redirect_valid,
   input  logic [PHYSICAL_ADDRESS_LENGTH-1:0] redirect_pc,
   output logic                               bundle_valid,
   input  logic                               bundle_ready,
   output logic [NFU*32-1:0]                  bundle_data,
   output logic [PHYSICAL_ADDRESS_LENGTH-1:0] bundle_pc,
   output logic                               fetch_fault
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]                        stat_fetches,
   output logic [31:0]                        stat_misses
`endif
);
   localparam int AW         = PHYSICAL_ADDRESS_LENGTH;
   localparam int BW         = NFU * 32;
   localparam int ALIGN_BITS = $clog2(NFU * 4);
   localparam int PW         = $clog2(QUEUE_DEPTH);
   localparam logic [AW-1:0] STRIDE = AW'(NFU * 4);
   localparam logic [PW:0]   DEPTH  = (PW + 1)'(QUEUE_DEPTH);

   typedef enum logic [2:0] {REQ, WAIT, MISS, DRAIN, FAULT} state_t;

   state_t        state;
   logic [AW-1:0] pc;
   logic          drain_refill;
   logic          drain_fault;

   logic [BW-1:0] q_data [QUEUE_DEPTH];
   logic [AW-1:0] q_pc   [QUEUE_DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [PW:0]   count;

   logic aligned;
   logic outstanding;
   logic resolved;
   logic push;
   logic pop;

   assign aligned     = (redirect_pc[ALIGN_BITS-1:0] == '0);
   assign outstanding = state inside {WAIT, MISS, DRAIN};
   // The in-flight request finishes this cycle: hit/miss while waiting, refill while missed.
   assign resolved = ((state == WAIT) && (cache_resp_valid || cache_miss))
                  || ((state == MISS) && refill_done)
                  || ((state == DRAIN) && (drain_refill ? refill_done
                                                        : (cache_resp_valid || cache_miss)));
   assign push = (state == WAIT) && cache_resp_valid && !cache_miss && !redirect_valid;
   assign pop  = bundle_valid && bundle_ready && !redirect_valid;

   assign cache_addr   = pc;
   assign bundle_valid = (count != '0);
   assign bundle_data  = bundle_valid ? q_data[rd_ptr] : '0;
   assign bundle_pc    = bundle_valid ? q_pc[rd_ptr]   : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= REQ;
         pc           <= RESET_PC;
         cache_req    <= 1'b0;
         fetch_fault  <= 1'b0;
         drain_refill <= 1'b0;
         drain_fault  <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout; the default below makes cache_req a one-cycle pulse.
         cache_req <= 1'b0;
         if (redirect_valid) begin
            pc          <= redirect_pc;
            fetch_fault <= !aligned;
            drain_fault <= !aligned;
            if (outstanding && !resolved) begin
               state        <= DRAIN;
               drain_refill <= (state == MISS) || ((state == DRAIN) && drain_refill);
            end else begin
               state <= aligned ? REQ : FAULT;
            end
         end else begin
            case (state)
               REQ: begin
                  if (count < DEPTH) begin
                     cache_req <= 1'b1;
                     state     <= WAIT;
                  end
               end
               WAIT: begin
                  if (cache_miss) begin
                     state <= MISS;
                  end else if (cache_resp_valid) begin
                     pc    <= pc + STRIDE;
                     state <= REQ;
                  end
               end
               MISS: begin
                  if (refill_done) state <= REQ;
               end
               DRAIN: begin
                  if (resolved) state <= drain_fault ? FAULT : REQ;
               end
               FAULT: state <= FAULT;
               default: state <= REQ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (redirect_valid) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      count <= count + (PW + 1)'(1);
         else if (pop && !push) count <= count - (PW + 1)'(1);
      end
   end

   // NOTE: queue storage is not reset; entries are only visible behind count, and the
   // head outputs are forced to zero while the queue is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         q_data[wr_ptr] <= cache_data;
         q_pc[wr_ptr]   <= pc;
      end
   end

`ifdef FETCH_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_fetches <= '0;
         stat_misses  <= '0;
      end else begin
         if (push && (stat_fetches != '1)) stat_fetches <= stat_fetches + 32'd1;
         if (cache_miss && (state != DRAIN) && (stat_misses != '1))
            stat_misses <= stat_misses + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural I-cache with programmable latency/miss,
// pop monitor, and hand-computed expected addresses and bundles.
module tb_fetch_unit;
   localparam int AW = 56;
   localparam int BW = 64;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cache_req;
   logic [AW-1:0] cache_addr;
   logic          cache_resp_valid;
   logic          cache_miss;
   logic [BW-1:0] cache_data;
   logic          refill_done;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic          bundle_valid;
   logic          bundle_ready;
   logic [BW-1:0] bundle_data;
   logic [AW-1:0] bundle_pc;
   logic          fetch_fault;
`ifdef FETCH_STATS_EN
   logic [31:0]   stat_fetches;
   logic [31:0]   stat_misses;
`endif

   fetch_unit dut (
      .clk(clk), .rst_n(rst_n),
      .cache_req(cache_req), .cache_addr(cache_addr),
      .cache_resp_valid(cache_resp_valid), .cache_miss(cache_miss),
      .cache_data(cache_data), .refill_done(refill_done),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .bundle_valid(bundle_valid), .bundle_ready(bundle_ready),
      .bundle_data(bundle_data), .bundle_pc(bundle_pc),
      .fetch_fault(fetch_fault)
`ifdef FETCH_STATS_EN
      , .stat_fetches(stat_fetches), .stat_misses(stat_misses)
`endif
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [BW-1:0] model_data(input logic [AW-1:0] a);
      return {a[31:0] ^ 32'h5A5A_0F0F, a[31:0] | 32'hC0DE_0000};
   endfunction

   // Behavioural I-cache
   int            lat        = 1;
   bit            hold       = 1'b0;
   bit            stale_mode = 1'b0;
   bit            miss_armed = 1'b0;
   logic [AW-1:0] miss_addr  = '0;
   int            cyc        = 0;
   logic [AW-1:0] req_q [$];
   int            req_cyc [$];
   int            refill_cyc = 0;
   int            timer      = 0;
   int            refill_cnt = 0;
   bit            miss_fired = 1'b0;
   logic [AW-1:0] pend_addr  = '0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      cache_resp_valid = 1'b0;
      cache_miss       = 1'b0;
      refill_done      = 1'b0;
      if (!rst_n) begin
         timer      = 0;
         refill_cnt = 0;
         miss_fired = 1'b0;
      end else begin
         if (refill_cnt > 0) begin
            refill_cnt--;
            if (refill_cnt == 0) begin
               refill_done = 1'b1;
               refill_cyc  = cyc;
            end
         end
         if (timer > 0) begin
            timer--;
            if (timer == 0) begin
               if (miss_armed && !miss_fired && pend_addr == miss_addr) begin
                  cache_miss = 1'b1;
                  miss_fired = 1'b1;
                  refill_cnt = 3;
               end else begin
                  cache_resp_valid = 1'b1;
                  cache_data = stale_mode ? 64'hDEAD_DEAD_DEAD_DEAD : model_data(pend_addr);
               end
            end
         end
         if (cache_req) begin
            req_q.push_back(cache_addr);
            req_cyc.push_back(cyc);
            if (!hold) begin
               timer     = lat;
               pend_addr = cache_addr;
            end
         end
      end
   end

   // Pop monitor: values read before the edge updates the DUT
   logic [AW-1:0] pop_pc [$];
   logic [BW-1:0] pop_data [$];
   always @(posedge clk) begin
      if (rst_n && bundle_valid && bundle_ready && !redirect_valid) begin
         pop_pc.push_back(bundle_pc);
         pop_data.push_back(bundle_data);
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_reqs(input int target, input int budget, input string tag);
      int n = 0;
      while (req_q.size() < target && n < budget) begin
         step();
         n++;
      end
      if (req_q.size() < target) check({tag, "_req_timeout"}, req_q.size(), target);
   endtask

   task automatic wait_pops(input int target, input int budget, input string tag);
      int n = 0;
      while (pop_pc.size() < target && n < budget) begin
         step();
         n++;
      end
      if (pop_pc.size() < target) check({tag, "_pop_timeout"}, pop_pc.size(), target);
   endtask

   int rb;
   int pb;
   int rc;

   task automatic do_reset();
      rst_n = 1'b0;
      step(2);
      rb = req_q.size();
      pb = pop_pc.size();
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n          = 1'b0;
      bundle_ready   = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      step(1);

      // Reset state
      check("rst_cache_req", cache_req, 0);
      check("rst_bundle_valid", bundle_valid, 0);
      check("rst_fault", fetch_fault, 0);
      check("rst_cache_addr", cache_addr, 0);
      check("rst_bundle_data", bundle_data, 0);
      check("rst_bundle_pc", bundle_pc, 0);
`ifdef FETCH_STATS_EN
      check("rst_stat_fetches", stat_fetches, 0);
      check("rst_stat_misses", stat_misses, 0);
`endif

      // Streaming hits, consumer always ready
      bundle_ready = 1'b1;
      rb = req_q.size();
      pb = pop_pc.size();
      rst_n = 1'b1;
      wait_pops(pb + 3, 60, "stream");
      check("stream_addr0", req_q[rb], 56'h0);
      check("stream_addr1", req_q[rb+1], 56'h8);
      check("stream_addr2", req_q[rb+2], 56'h10);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("stream_pc%0d", i), pop_pc[pb+i], 56'(i * 8));
         check($sformatf("stream_data%0d", i), pop_data[pb+i], model_data(56'(i * 8)));
      end

      // Back-pressure: queue fills to 4 and fetch stops; one pop frees one request
      bundle_ready = 1'b0;
      do_reset();
      step(30);
      check("full_req_count", req_q.size() - rb, 4);
      check("full_valid", bundle_valid, 1);
      check("full_head_pc", bundle_pc, 56'h0);
      check("full_no_req", cache_req, 0);
      bundle_ready = 1'b1;
      step(1);
      bundle_ready = 1'b0;
      step(10);
      check("full_one_pop", pop_pc.size() - pb, 1);
      check("full_popped_pc", pop_pc[pb], 56'h0);
      check("full_req_after_pop", req_q.size() - rb, 5);
      check("full_refetch_addr", req_q[rb+4], 56'h20);
      check("full_new_head_pc", bundle_pc, 56'h8);

      // Miss on 0x8: retry after refill, order intact
      miss_armed   = 1'b1;
      miss_addr    = 56'h8;
      bundle_ready = 1'b1;
      do_reset();
      wait_pops(pb + 3, 80, "miss");
      check("miss_addr0", req_q[rb], 56'h0);
      check("miss_addr1", req_q[rb+1], 56'h8);
      check("miss_retry_addr", req_q[rb+2], 56'h8);
      check("miss_addr3", req_q[rb+3], 56'h10);
      check("miss_retry_after_refill", req_cyc[rb+2] > refill_cyc, 1);
      check("miss_pop0", pop_pc[pb], 56'h0);
      check("miss_pop1", pop_pc[pb+1], 56'h8);
      check("miss_pop1_data", pop_data[pb+1], model_data(56'h8));
      check("miss_pop2", pop_pc[pb+2], 56'h10);
`ifdef FETCH_STATS_EN
      check("miss_stat_misses", stat_misses, 1);
`endif
      miss_armed = 1'b0;

      // Redirect while waiting: stale response dropped, queue flushed
      bundle_ready = 1'b0;
      lat = 4;
      do_reset();
      wait_reqs(rb + 2, 40, "redir");
      check("redir_pre_valid", bundle_valid, 1);
      redirect_valid = 1'b1;
      redirect_pc    = 56'h100;
      stale_mode     = 1'b1;
      step(1);
      redirect_valid = 1'b0;
      check("redir_flush", bundle_valid, 0);
      wait_reqs(rb + 3, 40, "redir2");
      stale_mode = 1'b0;
      check("redir_stale_dropped", bundle_valid, 0);
      check("redir_new_addr", req_q[rb+2], 56'h100);
      bundle_ready = 1'b1;
      pb = pop_pc.size();
      wait_pops(pb + 1, 40, "redir");
      check("redir_pop_pc", pop_pc[pb], 56'h100);
      check("redir_pop_data", pop_data[pb], model_data(56'h100));
      lat = 1;

      // Misaligned redirect halts fetch; aligned redirect recovers
      step(3);
      rc = req_q.size();
      redirect_valid = 1'b1;
      redirect_pc    = 56'h104;
      step(1);
      redirect_valid = 1'b0;
      check("fault_set", fetch_fault, 1);
      check("fault_flush", bundle_valid, 0);
      step(12);
      check("fault_no_req", req_q.size() - rc, 0);
      check("fault_held", fetch_fault, 1);
      redirect_valid = 1'b1;
      redirect_pc    = 56'h200;
      step(1);
      redirect_valid = 1'b0;
      check("fault_clear", fetch_fault, 0);
      wait_reqs(rc + 1, 20, "fault");
      check("fault_recover_addr", req_q[rc], 56'h200);

      // Reset while a request hangs with bundles queued
      bundle_ready = 1'b0;
      do_reset();
      wait_reqs(rb + 3, 40, "midrst");
      hold = 1'b1;
      step(8);
      check("midrst_pre_valid", bundle_valid, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", bundle_valid, 0);
      check("midrst_fault", fetch_fault, 0);
      check("midrst_req", cache_req, 0);
      check("midrst_addr", cache_addr, 56'h0);
`ifdef FETCH_STATS_EN
      check("midrst_stat_fetches", stat_fetches, 0);
      check("midrst_stat_misses", stat_misses, 0);
`endif
      step(2);
      hold = 1'b0;
      rc = req_q.size();
      rst_n = 1'b1;
      wait_reqs(rc + 1, 20, "midrst");
      check("midrst_first_addr", req_q[rc], 56'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
